// File: rtl/lsc_multi_channel.sv
// Multi-channel load/store controller: round-robin arbitration of core ports onto one DMA path.
// Optional read watchdog enabled by defining LSC_WATCHDOG_EN.
`timescale 1ns/1ps
module lsc_multi_channel #(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 128,
    parameter int HADDR_W  = 40,
    parameter int LADDR_W  = 12,
    parameter int LEN_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           core_req,
    input  logic [NUM_CH-1:0]           core_rwn,
    input  logic [NUM_CH*HADDR_W-1:0]   core_host_addr,
    input  logic [NUM_CH*LADDR_W-1:0]   core_local_addr,
    input  logic [NUM_CH*LEN_W-1:0]     core_len,
    input  logic [NUM_CH*DATA_W-1:0]    core_wr_data,
    output logic [NUM_CH-1:0]           core_grant,
    output logic [NUM_CH-1:0]           core_wr_ack,
    output logic [NUM_CH-1:0]           core_rd_valid,
    output logic [DATA_W-1:0]           core_rd_data,
    output logic [NUM_CH-1:0]           core_done,
    output logic [NUM_CH-1:0]           core_err,
    output logic                        dma_req,
    input  logic                        dma_resp,
    output logic                        dma_wr_valid,
    output logic [DATA_W-1:0]           dma_wr_data,
    input  logic                        dma_wr_ready,
    input  logic                        dma_rd_valid,
    input  logic [DATA_W-1:0]           dma_rd_data,
    output logic                        dma_rd_ready
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DESC  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                rwn_q, rwn_d;
    logic [HADDR_W-1:0]  haddr_q, haddr_d;
    logic [LADDR_W-1:0]  laddr_q, laddr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic                err_q, err_d;

    logic                arb_found;
    logic [CH_W-1:0]     arb_idx;
    logic [NUM_CH-1:0]   ch_sel;
    logic [DATA_W-1:0]   desc_beat;
    logic                wr_fire;
    logic                rd_fire;
    logic                last_beat;

    // First requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        int c;
        c         = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!arb_found && core_req[c]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(c);
            end
        end
    end

    assign ch_sel    = NUM_CH'(1) << ch_q;
    assign desc_beat = DATA_W'({(rwn_q ? 8'h01 : 8'h03), len_q, haddr_q, 4'b0000, laddr_q});
    assign last_beat = (beat_cnt_q == LEN_W'(len_q - 1'b1));

    assign dma_req      = (state_q == S_REQ);
    assign dma_wr_valid = (state_q == S_DESC) || (state_q == S_WDATA);
    assign dma_rd_ready = (state_q == S_RDATA);
    assign wr_fire      = dma_wr_valid && dma_wr_ready;
    assign rd_fire      = dma_rd_ready && dma_rd_valid;

    always_comb begin
        dma_wr_data = '0;
        if (state_q == S_DESC)
            dma_wr_data = desc_beat;
        else if (state_q == S_WDATA)
            dma_wr_data = core_wr_data[int'(ch_q)*DATA_W +: DATA_W];
    end

    assign core_grant    = grant_q;
    assign core_wr_ack   = (state_q == S_WDATA && dma_wr_ready) ? ch_sel : '0;
    assign core_rd_valid = rd_fire ? ch_sel : '0;
    assign core_rd_data  = dma_rd_data;
    assign core_done     = (state_q == S_DONE) ? ch_sel : '0;

`ifdef LSC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    assign core_err = (state_q == S_DONE && err_q) ? ch_sel : '0;
`else
    assign core_err = '0;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rr_ptr_d   = rr_ptr_q;
        rwn_d      = rwn_q;
        haddr_d    = haddr_q;
        laddr_d    = laddr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = '0;
        err_d      = err_q;
`ifdef LSC_WATCHDOG_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    ch_d    = arb_idx;
                    rwn_d   = core_rwn[arb_idx];
                    haddr_d = core_host_addr[int'(arb_idx)*HADDR_W +: HADDR_W];
                    laddr_d = core_local_addr[int'(arb_idx)*LADDR_W +: LADDR_W];
                    len_d   = core_len[int'(arb_idx)*LEN_W +: LEN_W];
                    grant_d = NUM_CH'(1) << arb_idx;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dma_resp)
                    state_d = S_DESC;
            end
            S_DESC: begin
`ifdef LSC_WATCHDOG_EN
                wdog_d = '0;
`endif
                if (wr_fire) begin
                    if (len_q == '0)
                        state_d = S_DONE;
                    else if (rwn_q)
                        state_d = S_RDATA;
                    else
                        state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                if (wr_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat)
                        state_d = S_DONE;
                end
            end
            S_RDATA: begin
                if (rd_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat)
                        state_d = S_DONE;
`ifdef LSC_WATCHDOG_EN
                    wdog_d = WD_W'(1);
                end else if (wdog_q >= WD_W'(WDOG_CYC - 1)) begin
                    // Counter includes the cycle of the last accepted beat.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                rr_ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            rr_ptr_q   <= '0;
            rwn_q      <= 1'b0;
            haddr_q    <= '0;
            laddr_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rr_ptr_q   <= rr_ptr_d;
            rwn_q      <= rwn_d;
            haddr_q    <= haddr_d;
            laddr_q    <= laddr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
        end
    end

`ifdef LSC_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog_q <= '0;
        else
            wdog_q <= wdog_d;
    end
`endif

endmodule

// File: tb/tb_lsc_multi_channel.sv
// Directed self-checking bench for lsc_multi_channel (two channels, 128-bit data).
`timescale 1ns/1ps
module tb_lsc_multi_channel;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 128;
    localparam int HADDR_W = 40;
    localparam int LADDR_W = 12;
    localparam int LEN_W   = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          core_req;
    logic [NUM_CH-1:0]          core_rwn;
    logic [NUM_CH*HADDR_W-1:0]  core_host_addr;
    logic [NUM_CH*LADDR_W-1:0]  core_local_addr;
    logic [NUM_CH*LEN_W-1:0]    core_len;
    logic [NUM_CH*DATA_W-1:0]   core_wr_data;
    logic [NUM_CH-1:0]          core_grant;
    logic [NUM_CH-1:0]          core_wr_ack;
    logic [NUM_CH-1:0]          core_rd_valid;
    logic [DATA_W-1:0]          core_rd_data;
    logic [NUM_CH-1:0]          core_done;
    logic [NUM_CH-1:0]          core_err;
    logic                       dma_req;
    logic                       dma_resp;
    logic                       dma_wr_valid;
    logic [DATA_W-1:0]          dma_wr_data;
    logic                       dma_wr_ready;
    logic                       dma_rd_valid;
    logic [DATA_W-1:0]          dma_rd_data;
    logic                       dma_rd_ready;

    int passed = 0;
    int total  = 0;

    lsc_multi_channel #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HADDR_W(HADDR_W),
        .LADDR_W(LADDR_W), .LEN_W(LEN_W), .WDOG_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_rwn(core_rwn),
        .core_host_addr(core_host_addr), .core_local_addr(core_local_addr),
        .core_len(core_len), .core_wr_data(core_wr_data),
        .core_grant(core_grant), .core_wr_ack(core_wr_ack),
        .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
        .core_done(core_done), .core_err(core_err),
        .dma_req(dma_req), .dma_resp(dma_resp),
        .dma_wr_valid(dma_wr_valid), .dma_wr_data(dma_wr_data),
        .dma_wr_ready(dma_wr_ready), .dma_rd_valid(dma_rd_valid),
        .dma_rd_data(dma_rd_data), .dma_rd_ready(dma_rd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dma_req"},       128'(dma_req),       128'h0);
        check({tag, " dma_wr_valid"},  128'(dma_wr_valid),  128'h0);
        check({tag, " dma_wr_data"},   dma_wr_data,         128'h0);
        check({tag, " dma_rd_ready"},  128'(dma_rd_ready),  128'h0);
        check({tag, " core_grant"},    128'(core_grant),    128'h0);
        check({tag, " core_wr_ack"},   128'(core_wr_ack),   128'h0);
        check({tag, " core_rd_valid"}, 128'(core_rd_valid), 128'h0);
        check({tag, " core_rd_data"},  core_rd_data,        128'h0);
        check({tag, " core_done"},     128'(core_done),     128'h0);
        check({tag, " core_err"},      128'(core_err),      128'h0);
    endtask

    initial begin
        rst             = 1'b1;
        core_req        = '0;
        core_rwn        = '0;
        core_host_addr  = '0;
        core_local_addr = '0;
        core_len        = '0;
        core_wr_data    = '0;
        dma_resp        = 1'b0;
        dma_wr_ready    = 1'b0;
        dma_rd_valid    = 1'b0;
        dma_rd_data     = '0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single write ch0, len 3
        core_req                  = 2'b01;
        core_rwn                  = 2'b00;
        core_host_addr[0 +: 40]   = 40'h12_3456_7890;
        core_local_addr[0 +: 12]  = 12'h0AB;
        core_len[0 +: 16]         = 16'd3;
        core_wr_data[0 +: 128]    = 128'h1111;
        dma_wr_ready              = 1'b1;
        tick(); #1;
        check("wr grant", 128'(core_grant), 128'h1);
        check("wr dma_req", 128'(dma_req), 128'h1);
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick(); #1;
        check("wr desc valid", 128'(dma_wr_valid), 128'h1);
        check("wr desc data", dma_wr_data, 128'h030003123456789000AB);
        check("wr desc req low", 128'(dma_req), 128'h0);
        check("wr desc grant low", 128'(core_grant), 128'h0);
        dma_resp = 1'b0;
        tick(); #1;
        check("wr beat0 data", dma_wr_data, 128'h1111);
        check("wr beat0 ack", 128'(core_wr_ack), 128'h1);
        tick();
        core_wr_data[0 +: 128] = 128'h2222;
        #1;
        check("wr beat1 data", dma_wr_data, 128'h2222);
        check("wr beat1 ack", 128'(core_wr_ack), 128'h1);
        tick();
        core_wr_data[0 +: 128] = 128'h3333;
        #1;
        check("wr beat2 data", dma_wr_data, 128'h3333);
        check("wr beat2 ack", 128'(core_wr_ack), 128'h1);
        check("wr not done early", 128'(core_done), 128'h0);
        tick(); #1;
        check("wr done", 128'(core_done), 128'h1);
        check("wr done no ack", 128'(core_wr_ack), 128'h0);
        check("wr done no valid", 128'(dma_wr_valid), 128'h0);
        tick(); #1;
        check("wr done single pulse", 128'(core_done), 128'h0);

        // Read ch1, len 2
        core_req                   = 2'b10;
        core_rwn                   = 2'b10;
        core_host_addr[40 +: 40]   = 40'hAA_BBCC_DDEE;
        core_local_addr[12 +: 12]  = 12'h123;
        core_len[16 +: 16]         = 16'd2;
        tick(); #1;
        check("rd grant", 128'(core_grant), 128'h2);
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick(); #1;
        check("rd desc data", dma_wr_data, 128'h010002AABBCCDDEE0123);
        dma_resp = 1'b0;
        tick(); #1;
        check("rd ready", 128'(dma_rd_ready), 128'h1);
        check("rd idle valid", 128'(core_rd_valid), 128'h0);
        dma_rd_valid = 1'b1;
        dma_rd_data  = {16{8'hA5}};
        #1;
        check("rd beat0 valid", 128'(core_rd_valid), 128'h2);
        check("rd beat0 data", core_rd_data, {16{8'hA5}});
        tick();
        dma_rd_data = {16{8'h5A}};
        #1;
        check("rd beat1 valid", 128'(core_rd_valid), 128'h2);
        check("rd beat1 data", core_rd_data, {16{8'h5A}});
        tick();
        #1;
        check("rd done", 128'(core_done), 128'h2);
        check("rd extra beat not accepted", 128'(core_rd_valid), 128'h0);
        check("rd done ready low", 128'(dma_rd_ready), 128'h0);
        dma_rd_valid = 1'b0;
        dma_rd_data  = '0;
        tick();

        // Both channels requesting, len 1: grants alternate
        core_req          = 2'b11;
        core_rwn          = 2'b00;
        core_len[0 +: 16] = 16'd1;
        core_len[16 +: 16] = 16'd1;
        dma_resp          = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check($sformatf("rr grant %0d", k), 128'(core_grant), (k % 2 == 0) ? 128'h1 : 128'h2);
            repeat (4) tick();
        end
        core_req = 2'b00;
        dma_resp = 1'b0;

        // len 0 write with ready toggling on the descriptor
        core_req                  = 2'b01;
        core_host_addr[0 +: 40]   = 40'h0F_EDCB_A987;
        core_local_addr[0 +: 12]  = 12'hFFF;
        core_len[0 +: 16]         = 16'd0;
        dma_wr_ready              = 1'b0;
        tick(); #1;
        check("len0 grant", 128'(core_grant), 128'h1);
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick(); #1;
        dma_resp = 1'b0;
        check("len0 desc", dma_wr_data, 128'h0300000FEDCBA9870FFF);
        check("len0 desc no ack", 128'(core_wr_ack), 128'h0);
        tick(); #1;
        check("len0 desc held", dma_wr_data, 128'h0300000FEDCBA9870FFF);
        check("len0 desc valid held", 128'(dma_wr_valid), 128'h1);
        dma_wr_ready = 1'b1;
        #1;
        check("len0 desc still held", dma_wr_data, 128'h0300000FEDCBA9870FFF);
        tick(); #1;
        check("len0 done", 128'(core_done), 128'h1);
        check("len0 no payload", 128'(dma_wr_valid), 128'h0);
        tick();

        // Reset in WDATA after 1 of 4 beats (rr_ptr points at ch1 here)
        core_req           = 2'b10;
        core_rwn           = 2'b00;
        core_len[16 +: 16] = 16'd4;
        tick(); #1;
        check("abort grant", 128'(core_grant), 128'h2);
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick();
        dma_resp = 1'b0;
        tick(); #1;
        check("abort beat0 ack", 128'(core_wr_ack), 128'h2);
        tick(); #1;
        check("abort beat1 ack", 128'(core_wr_ack), 128'h2);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick(); #1;
        check("abort no done", 128'(core_done), 128'h0);
        rst      = 1'b0;
        core_req = 2'b11;
        tick(); #1;
        check("post reset grant ch0", 128'(core_grant), 128'h1);
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick();
        dma_resp = 1'b0;
        tick(); #1;
        check("post reset done", 128'(core_done), 128'h1);
        tick();

`ifdef LSC_WATCHDOG_EN
        // Read ch1 len 4, one beat only: abort 16 cycles after that beat
        core_req           = 2'b10;
        core_rwn           = 2'b10;
        core_len[16 +: 16] = 16'd4;
        tick();
        core_req = 2'b00;
        dma_resp = 1'b1;
        tick();
        dma_resp = 1'b0;
        tick();
        dma_rd_valid = 1'b1;
        dma_rd_data  = 128'hC0FFEE;
        #1;
        check("wdog beat", 128'(core_rd_valid), 128'h2);
        tick();
        dma_rd_valid = 1'b0;
        repeat (14) tick();
        #1;
        check("wdog not yet done", 128'(core_done), 128'h0);
        check("wdog not yet err", 128'(core_err), 128'h0);
        tick(); #1;
        check("wdog done", 128'(core_done), 128'h2);
        check("wdog err", 128'(core_err), 128'h2);
        tick(); #1;
        check("wdog err single pulse", 128'(core_err), 128'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsc_multi_channel.md
# lsc_multi_channel

Parametrised multi-channel load/store controller between NUM_CH FPU core ports and the single DMA path controller. It round-robin arbitrates core transfer requests and captures the winning command. It then issues a descriptor beat followed by write payload beats, or collects read return beats. Read data is routed to the owning channel, and the channel receives a done pulse on completion.

## Interface
- NUM_CH, 2: number of core channels (1..8)
- DATA_W, 128: DMA/core data width; must be ≥ 8+LEN_W+HADDR_W+4+LADDR_W
- HADDR_W, 40: host address width
- LADDR_W, 12: local address width
- LEN_W, 16: transfer length width, in beats
- WDOG_CYC, 1024: read watchdog limit, in cycles (used only with LSC_WATCHDOG_EN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- core_req  in  NUM_CH  per-channel transfer request, level
- core_rwn  in  NUM_CH  1 = read (host→local), 0 = write
- core_host_addr  in  NUM_CH*HADDR_W  packed host addresses; channel i at [i*HADDR_W +: HADDR_W]
- core_local_addr  in  NUM_CH*LADDR_W  packed local addresses
- core_len  in  NUM_CH*LEN_W  packed payload beat counts
- core_wr_data  in  NUM_CH*DATA_W  packed write payload
- core_grant  out  NUM_CH  one-hot, 1-cycle pulse: command captured
- core_wr_ack  out  NUM_CH  write beat consumed; present next beat on the following cycle
- core_rd_valid  out  NUM_CH  read beat valid for channel
- core_rd_data  out  DATA_W  shared read data
- core_done  out  NUM_CH  1-cycle completion pulse
- core_err  out  NUM_CH  1-cycle watchdog abort pulse, coincident with core_done
- dma_req  out  1  path request
- dma_resp  in  1  path granted
- dma_wr_valid  out  1  descriptor/payload beat valid
- dma_wr_data  out  DATA_W  descriptor/payload
- dma_wr_ready  in  1  path accepts beat
- dma_rd_valid  in  1  read return beat valid
- dma_rd_data  in  DATA_W  read return data
- dma_rd_ready  out  1  controller accepts read beat

## Operation
- States: IDLE, REQ, DESC, WDATA, RDATA, DONE.
- IDLE: if any core_req is set, grant the first requester at or after rr_ptr (cyclic). Capture rwn, addresses and len into registers, pulse core_grant[g], set dma_req, and go to REQ. Captured values are used for the rest of the transfer; core inputs may change after grant.
- REQ: hold dma_req until dma_resp is sampled high; then clear dma_req and go to DESC.
- DESC: dma_wr_valid=1. dma_wr_data = {zero pad, opcode[7:0], len, host_addr, 4'b0, local_addr}, with local_addr at the LSB. Opcode is 8'h03 for write, 8'h01 for read. On beat transfer (valid && ready): a write with len>0 goes to WDATA; a read with len>0 goes to RDATA; len=0 goes to DONE.
- WDATA: dma_wr_valid=1 and dma_wr_data = core_wr_data[g], both combinational. Each transfer pulses core_wr_ack[g] and increments beat_cnt. The transfer with beat_cnt==len-1 goes to DONE.
- RDATA: dma_rd_ready=1. core_rd_valid[g] = dma_rd_valid. core_rd_data = dma_rd_data at all times. Each beat increments beat_cnt; beat len-1 goes to DONE.
- DONE: pulse core_done[g], set rr_ptr = (g+1) mod NUM_CH, clear beat_cnt, go to IDLE.
- beat_cnt is LEN_W bits and never wraps; it stops at len.
- dma_rd_valid outside RDATA is not accepted (dma_rd_ready=0).
- dma_resp outside REQ is ignored.
- A core_req deasserted before grant is not serviced.

## Timing
- Reset values: dma_req=0, dma_wr_valid=0, dma_wr_data=0, dma_rd_ready=0, and all core_* outputs 0. State=IDLE, rr_ptr=0, beat_cnt=0.
- Reset mid-transfer aborts immediately. No done pulse is issued.
- Registered timing: core_grant and dma_req assert the cycle after core_req is seen in IDLE. DESC is entered the cycle after dma_resp is sampled.
- Best-case write of N beats: 1 (grant) + 1 (resp) + 1 (desc) + N + 1 (done) cycles. core_done pulses in the cycle after the last beat.
- Read path has zero latency: core_rd_valid and core_rd_data are combinational from the dma_rd_* inputs.
- Back-to-back: the cycle after DONE is IDLE, and arbitration resumes from the new rr_ptr.

## Configuration
- LSC_WATCHDOG_EN defined: a cycle counter in RDATA resets on every accepted beat. If it reaches WDOG_CYC, the block enters DONE and pulses core_err[g] together with core_done[g].
- LSC_WATCHDOG_EN undefined: no counter, core_err is tied to 0, and RDATA waits indefinitely.

## Test plan
- Single write, ch0, len=3, host 0x12_3456_7890, local 0x0AB, ready always high: descriptor 0x03|0003|1234567890|0|0AB, 3 core_wr_ack[0] pulses, core_done[0] exactly 1 cycle after the last beat.
- Read, ch1, len=2, rd beats 0xA5.., 0x5A..: descriptor opcode 0x01, core_rd_valid[1] exactly twice with matching data, core_done[1]; core_rd_valid[0] stays 0.
- Both channels requesting continuously, len=1: grants alternate ch0, ch1, ch0, ch1.
- len=0 write, and dma_wr_ready toggling on the descriptor: only the descriptor beat is transferred, then core_done; the descriptor is held stable while ready=0.
- rst asserted in WDATA after 1 of 4 beats: all outputs 0 in the same cycle, no core_done; a new request after release is serviced from ch0.
- With LSC_WATCHDOG_EN and WDOG_CYC=16: a read with len=4 receiving only 1 beat -> core_err and core_done pulse together 16 cycles after that beat.
